// File: rtl/switch_debounce_sync.sv
// Switch/button conditioner: 2-flop synchronizer plus per-bit stability counter,
// with a registered change strobe and per-bit change mask for the switch PIO.
module switch_debounce_sync #(
  parameter int unsigned      WIDTH           = 17,
  parameter int unsigned      CNT_WIDTH       = 16,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             enable,
  output logic [WIDTH-1:0] sw_debounced,
  output logic             change_pulse,
  output logic [WIDTH-1:0] change_mask
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] update;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 upd;

    always_comb begin
      cnt_next = cnt;
      upd      = 1'b0;
      if (enable) begin
        if (sync2[i] == sw_debounced[i]) begin
          cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_next = '0;
          upd      = 1'b1;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end

    assign update[i] = upd;
  end

  // An accepted bit always differs from its current level, so the update is a toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_debounced <= RESET_VALUE;
      change_pulse <= 1'b0;
      change_mask  <= '0;
    end else begin
      sw_debounced <= sw_debounced ^ update;
      change_pulse <= |update;
      change_mask  <= update;
    end
  end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Randomized and directed bench for switch_debounce_sync with a run-length
// reference model of the debounce rules.
module tb_switch_debounce_sync;

  localparam int W = 17;
  localparam int D = 4;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic         enable;
  logic [W-1:0] sw_debounced;
  logic         change_pulse;
  logic [W-1:0] change_mask;

  int checks;
  int errors;

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_deb, m_mask;
  logic         m_pulse;
  int           m_run [W];

  switch_debounce_sync #(
    .WIDTH(W),
    .CNT_WIDTH(4),
    .DEBOUNCE_CYCLES(D),
    .RESET_VALUE('0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
    .enable(enable),
    .sw_debounced(sw_debounced),
    .change_pulse(change_pulse),
    .change_mask(change_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_pulse = 1'b0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic set_reset(input logic v);
    reset_n = v;
    if (!v) model_clear();
  endtask

  // Advance the model for the coming edge, then let the edge happen.
  task automatic step();
    logic [W-1:0] acc;
    acc = '0;
    if (!reset_n) begin
      model_clear();
    end else begin
      if (enable) begin
        for (int i = 0; i < W; i++) begin
          if (m_s2[i] !== m_deb[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] >= D) begin
              acc[i]   = 1'b1;
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_deb   = m_deb ^ acc;
      m_mask  = acc;
      m_pulse = |acc;
      m_s2    = m_s1;
      m_s1    = sw_raw;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sw_raw = '0;
    enable = 1'b1;
    set_reset(1'b0);
    step();
    step();
    set_reset(1'b1);
  endtask

  task automatic test_reset();
    sw_raw = 17'h15A5A;
    enable = 1'b1;
    set_reset(1'b0);
    #1;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (sw_debounced !== '0 || change_pulse !== 1'b0 || change_mask !== '0) begin
        errors++;
        $display("FAIL reset_state: deb=%h pulse=%b mask=%h required 0/0/0",
                 sw_debounced, change_pulse, change_mask);
      end
    end
    set_reset(1'b1);
  endtask

  task automatic test_single_bit();
    logic [W-1:0] e_deb, e_mask;
    logic         e_pulse;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      if (n == 10) sw_raw = 17'h00001;
      step();
      e_deb   = (n >= 15) ? 17'h00001 : 17'h00000;
      e_pulse = (n == 15);
      e_mask  = (n == 15) ? 17'h00001 : 17'h00000;
      checks++;
      if (sw_debounced !== e_deb || change_pulse !== e_pulse || change_mask !== e_mask) begin
        errors++;
        $display("FAIL single_bit edge %0d: deb=%h pulse=%b mask=%h required %h/%b/%h",
                 n, sw_debounced, change_pulse, change_mask, e_deb, e_pulse, e_mask);
      end
    end
  endtask

  task automatic test_glitch();
    int pat [4] = '{3, 1, 3, 8};
    logic lvl;
    lvl = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < pat[p]; c++) begin
        sw_raw[3] = lvl;
        step();
        checks++;
        if (sw_debounced[3] !== 1'b0 || change_pulse !== 1'b0 || sw_debounced !== m_deb) begin
          errors++;
          $display("FAIL glitch: deb=%h pulse=%b required deb[3]=0 pulse=0 deb=%h",
                   sw_debounced, change_pulse, m_deb);
        end
      end
      lvl = ~lvl;
      if (p == 2) lvl = 1'b0;
    end
  endtask

  task automatic test_all_bits();
    int pulses;
    pulses = 0;
    do_reset();
    sw_raw = 17'h1FFFF;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (change_pulse === 1'b1) begin
        pulses++;
        checks++;
        if (n != 6 || change_mask !== 17'h1FFFF || sw_debounced !== 17'h1FFFF) begin
          errors++;
          $display("FAIL all_bits pulse at edge %0d: mask=%h deb=%h required edge 6 mask=1ffff deb=1ffff",
                   n, change_mask, sw_debounced);
        end
      end
    end
    checks++;
    if (pulses != 1 || sw_debounced !== 17'h1FFFF) begin
      errors++;
      $display("FAIL all_bits count: pulses=%0d deb=%h required 1 and 1ffff", pulses, sw_debounced);
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    sw_raw = 17'h00020;
    step();
    step();
    set_reset(1'b0);
    #1;
    checks++;
    if (sw_debounced !== '0 || change_pulse !== 1'b0 || change_mask !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: deb=%h pulse=%b mask=%h required 0/0/0",
               sw_debounced, change_pulse, change_mask);
    end
    step();
    set_reset(1'b1);
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (sw_debounced[5] !== (n >= 6) || change_pulse !== (n == 6)) begin
        errors++;
        $display("FAIL midreset_restart edge %0d: deb5=%b pulse=%b required %b/%b",
                 n, sw_debounced[5], change_pulse, n >= 6, n == 6);
      end
    end
  endtask

  task automatic test_enable_hold();
    do_reset();
    sw_raw = 17'h00001;
    for (int n = 1; n <= 14; n++) begin
      enable = !(n >= 5 && n <= 10);
      step();
      checks++;
      if (sw_debounced[0] !== (n >= 12) || change_pulse !== (n == 12) ||
          change_mask !== ((n == 12) ? 17'h00001 : 17'h00000)) begin
        errors++;
        $display("FAIL enable_hold edge %0d: deb0=%b pulse=%b mask=%h required %b/%b",
                 n, sw_debounced[0], change_pulse, change_mask, n >= 12, n == 12);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_falling();
    do_reset();
    sw_raw = 17'h00004;
    for (int n = 1; n <= 18; n++) begin
      if (n == 11) sw_raw = '0;
      step();
      checks++;
      if (sw_debounced[2] !== (n >= 6 && n < 16) || change_pulse !== (n == 6 || n == 16) ||
          change_mask !== ((n == 6 || n == 16) ? 17'h00004 : 17'h00000)) begin
        errors++;
        $display("FAIL falling edge %0d: deb2=%b pulse=%b mask=%h", n, sw_debounced[2],
                 change_pulse, change_mask);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5, 0) == 0) sw_raw[$urandom_range(W - 1, 0)] ^= 1'b1;
      if ($urandom_range(3, 0) == 0) sw_raw = sw_raw ^ W'(1 << $urandom_range(W - 1, 0));
      enable = ($urandom_range(9, 0) != 0);
      if ($urandom_range(399, 0) == 0) begin
        set_reset(1'b0);
        #1;
        step();
        set_reset(1'b1);
      end
      step();
      checks++;
      if (sw_debounced !== m_deb || change_pulse !== m_pulse || change_mask !== m_mask) begin
        errors++;
        $display("FAIL random cycle %0d: deb=%h pulse=%b mask=%h required %h/%b/%h",
                 n, sw_debounced, change_pulse, change_mask, m_deb, m_pulse, m_mask);
      end
    end
    enable = 1'b1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b1;
    sw_raw  = '0;
    enable  = 1'b1;
    model_clear();
    test_reset();
    test_single_bit();
    test_glitch();
    test_all_bits();
    test_reset_midcount();
    test_enable_hold();
    test_falling();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce_sync.md
Name: switch_debounce_sync

Overview:
- Conditions the raw DE-board slide-switch/push-button pins before they reach the 17-bit switch PIO input slave.
- Each bit passes through a 2-flop synchronizer, then a per-bit stability counter. A bit's output changes only after its input has held a new level for DEBOUNCE_CYCLES consecutive clocks.
- Drives the PIO's in_port directly and emits a one-cycle change strobe plus a per-bit change mask.

Parameters:
- WIDTH, 17, number of switch bits conditioned.
- CNT_WIDTH, 16, width of each stability counter; must satisfy 2^CNT_WIDTH >= DEBOUNCE_CYCLES.
- DEBOUNCE_CYCLES, 50000, clocks a new level must persist before acceptance (1 ms at 50 MHz); legal range 1..2^CNT_WIDTH.
- RESET_VALUE, 0 (WIDTH bits), value loaded into the sync flops and debounced outputs at reset.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- sw_raw  input  WIDTH  asynchronous raw switch/button pins.
- enable  input  1  1 = counters run; 0 = counters hold their value and outputs freeze.
- sw_debounced  output  WIDTH  conditioned level; feeds the PIO in_port.
- change_pulse  output  1  high for exactly one cycle when any sw_debounced bit updates.
- change_mask  output  WIDTH  bits updated on that cycle; all-zero when change_pulse=0.

Behaviour:
- Reset (asynchronous assert; deassert used synchronously by all flops):
  - sync1, sync2, sw_debounced = RESET_VALUE.
  - All counters = 0; change_pulse = 0; change_mask = 0.
  - Reset asserted mid-count discards the partial count. After release, debounce restarts from zero.
- Synchronizer: sync1 <= sw_raw; sync2 <= sync1. No logic between the two stages.
- Per bit i, on each rising clk edge when enable=1:
  - mismatch = (sync2[i] != sw_debounced[i]).
  - mismatch=0: cnt[i] <= 0.
  - mismatch=1 and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - mismatch=1 and cnt[i] == DEBOUNCE_CYCLES-1: sw_debounced[i] <= sync2[i]; cnt[i] <= 0; change_mask[i] <= 1 for one cycle.
- Glitch rejection: any cycle where sync2 returns to the debounced level clears the counter. Acceptance requires an unbroken run of DEBOUNCE_CYCLES cycles.
- Latency: a clean step on sw_raw just before edge k makes sw_debounced change at edge k+1+DEBOUNCE_CYCLES (2 sync edges, then DEBOUNCE_CYCLES-1 counting edges, then the update edge).
- DEBOUNCE_CYCLES=1: bit updates on the first cycle of mismatch (pure synchronizer plus 1 register).
- change_pulse is registered: change_pulse <= OR of the next-state update bits. It is coincident with the cycle in which sw_debounced shows the new value. change_mask is registered identically.
- Simultaneous updates: several bits may update on the same edge. change_pulse stays a single pulse and change_mask holds all of them.
- enable=0:
  - Counters, sw_debounced and the sync→counter path hold.
  - Sync flops keep sampling.
  - change_pulse and change_mask are forced to 0.
  - On enable returning to 1, counting resumes from the held counts.
- Counters never exceed DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Bits are fully independent apart from the shared change_pulse OR.
- Expected size: ~150 lines of RTL (generate loop over WIDTH).

Test Plan (bench with DEBOUNCE_CYCLES=4, WIDTH=17, RESET_VALUE=0):
1. Reset, then sw_raw=17'h00001 held steady from edge 10:
   - sw_debounced=17'h00001 at edge 15 (=10+1+4).
   - change_pulse=1 and change_mask=17'h00001 for exactly that cycle; 0 before and after.
2. Bit 3 toggled high for 3 cycles, low for 1, high for 3, then low:
   - sw_debounced[3] stays 0 throughout; change_pulse never asserts.
3. sw_raw=17'h1FFFF applied in a single cycle from 0:
   - All 17 bits update on the same edge.
   - One change_pulse; change_mask=17'h1FFFF.
4. Bit 5 high for 2 cycles, then reset_n pulsed low for 1 cycle, bit 5 still held high:
   - Outputs 0 during reset.
   - sw_debounced[5] rises 1+4 edges after the first edge following release, not earlier.
5. Bit 0 step high; enable driven 0 for 6 cycles after 2 counting cycles, then back to 1:
   - No update while enable=0.
   - Update occurs 2 counting cycles after re-enable (the count resumes from 2).
6. After bit 2 has settled at 1, step it back to 0:
   - sw_debounced[2] falls 5 edges later.
   - change_mask=17'h00004 pulse (the falling edge is also reported).
